// File: rtl/arbitrated_blocking_channel.sv
// Merges NUM_IN message lanes, each with its own FIFO, onto one link through a round-robin arbiter.
// Latency: a word written at edge t can appear on out_data after edge t+1. Throughput is 1 word/clk.
// Backpressure: out_is_taken low holds the output stage. Lanes then fill up to the registered in_is_full.
module arbitrated_blocking_channel #(
    parameter int WIDTH              = 8,
    parameter int DEPTH              = 16,
    parameter int NUM_IN             = 4,
    parameter int ALMOST_FULL_MARGIN = 2,
    localparam int SW                = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    initialize,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_is_full,
    output logic [NUM_IN-1:0]       in_almost_full,
    output logic [NUM_IN-1:0]       overflow,
    output logic [WIDTH-1:0]        out_data,
    output logic [SW-1:0]           out_source,
    output logic                    out_valid,
    input  logic                    out_is_taken
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - ALMOST_FULL_MARGIN);

    logic                clear;
    logic [WIDTH-1:0]    mem [NUM_IN][DEPTH];
    logic [AW-1:0]       wr_ptr [NUM_IN];
    logic [AW-1:0]       rd_ptr [NUM_IN];
    logic [CW-1:0]       count_q [NUM_IN];
    logic [CW-1:0]       count_nxt [NUM_IN];
    logic [NUM_IN-1:0]   full_q;
    logic [NUM_IN-1:0]   afull_q;
    logic [NUM_IN-1:0]   ovf_q;
    logic [NUM_IN-1:0]   wr;
    logic [NUM_IN-1:0]   rd;
    logic [NUM_IN-1:0]   nonempty;
    logic [SW-1:0]       rr_ptr;
    logic [SW-1:0]       gnt_idx;
    logic                gnt_vld;
    logic                load_en;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic [SW-1:0]       out_source_q;
    logic [WIDTH-1:0]    head_dat;
    int                  idx;

    assign clear          = reset || initialize;
    assign load_en        = !out_valid_q || out_is_taken;
    assign in_is_full     = full_q;
    assign in_almost_full = afull_q;
    assign overflow       = ovf_q;
    assign out_data       = out_data_q;
    assign out_source     = out_source_q;
    assign out_valid      = out_valid_q;

    // Emptiness uses the registered count, so a word written this cycle cannot bypass to the output.
    always_comb begin
        wr       = '0;
        nonempty = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            wr[i]       = in_valid[i] && !full_q[i] && !clear;
            nonempty[i] = (count_q[i] != '0);
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_IN;
            if (!gnt_vld && nonempty[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            rd[i]        = load_en && gnt_vld && (gnt_idx == SW'(i));
            count_nxt[i] = count_q[i] + CW'(wr[i]) - CW'(rd[i]);
        end
        head_dat = mem[gnt_idx][rd_ptr[gnt_idx]];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < NUM_IN; i++) begin
                count_q[i] <= '0;
                wr_ptr[i]  <= '0;
                rd_ptr[i]  <= '0;
            end
            full_q       <= '0;
            afull_q      <= '0;
            ovf_q        <= '0;
            rr_ptr       <= SW'(NUM_IN - 1);
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_source_q <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                count_q[i] <= count_nxt[i];
                full_q[i]  <= (count_nxt[i] == FULL_LVL);
                afull_q[i] <= (count_nxt[i] >= AFULL_LVL);
                if (wr[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (rd[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (in_valid[i] && full_q[i]) ovf_q[i] <= 1'b1;
            end
            if (load_en) begin
                out_valid_q <= gnt_vld;
                if (gnt_vld) begin
                    out_data_q   <= head_dat;
                    out_source_q <= gnt_idx;
                    rr_ptr       <= gnt_idx;
                end
            end
        end
    end

    // Lane storage carries no reset; only the pointers and counts define its contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr[i]) mem[i][wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_arbitrated_blocking_channel.sv
// Directed bench for arbitrated_blocking_channel with hand-computed expected values.
module tb_arbitrated_blocking_channel;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int NUM_IN = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    initialize;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_is_full;
    logic [NUM_IN-1:0]       in_almost_full;
    logic [NUM_IN-1:0]       overflow;
    logic [WIDTH-1:0]        out_data;
    logic [1:0]              out_source;
    logic                    out_valid;
    logic                    out_is_taken;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    arbitrated_blocking_channel #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_IN(NUM_IN), .ALMOST_FULL_MARGIN(2)
    ) dut (
        .clk(clk), .reset(reset), .initialize(initialize),
        .in_data(in_data), .in_valid(in_valid),
        .in_is_full(in_is_full), .in_almost_full(in_almost_full), .overflow(overflow),
        .out_data(out_data), .out_source(out_source), .out_valid(out_valid),
        .out_is_taken(out_is_taken)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [7:0] d);
        in_data[lane*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset;
        reset = 1'b1; initialize = 1'b0; in_valid = '0; in_data = '0; out_is_taken = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state and single-word latency
        do_reset;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_source", out_source, 0);
        check("rst_full", in_is_full, 0);
        check("rst_afull", in_almost_full, 0);
        check("rst_ovf", overflow, 0);
        in_valid = 4'b0100; set_lane(2, 8'h11);
        tick;
        check("lat_valid_e1", out_valid, 0);
        in_valid = '0;
        tick;
        check("lat_valid_e2", out_valid, 1);
        check("lat_data", out_data, 8'h11);
        check("lat_src", out_source, 2);
        check("lat_full", in_is_full, 0);
        out_is_taken = 1'b1;
        tick;
        check("lat_drained", out_valid, 0);
        out_is_taken = 1'b0;

        // Fill lane 0 to full, then overflow
        do_reset;
        for (int k = 0; k < 17; k++) begin
            in_valid = 4'b0001; set_lane(0, 8'(8'h40 + k));
            tick;
            if (k == 13) check("fill_afull_13", in_almost_full[0], 0);
            if (k == 14) check("fill_afull_14", in_almost_full[0], 1);
            if (k == 15) check("fill_full_15", in_is_full[0], 0);
            if (k == 16) check("fill_full_16", in_is_full[0], 1);
        end
        set_lane(0, 8'h51);
        tick;
        check("fill_ovf", overflow[0], 1);
        check("fill_full_hold", in_is_full[0], 1);
        check("fill_stage", out_data, 8'h40);
        in_valid = '0; out_is_taken = 1'b1;
        for (int j = 0; j < 17; j++) begin
            check($sformatf("fill_drain_v%0d", j), out_valid, 1);
            check($sformatf("fill_drain_d%0d", j), out_data, 8'(8'h40 + j));
            tick;
        end
        check("fill_no_dropped", out_valid, 0);
        out_is_taken = 1'b0;

        // Round robin across four preloaded lanes
        do_reset;
        for (int w = 0; w < 3; w++) begin
            in_valid = 4'b1111;
            for (int l = 0; l < NUM_IN; l++) set_lane(l, 8'(l * 16 + w));
            tick;
        end
        in_valid = '0; out_is_taken = 1'b1;
        for (int n = 0; n < 12; n++) begin
            check($sformatf("rr_v%0d", n), out_valid, 1);
            check($sformatf("rr_src%0d", n), out_source, n % 4);
            check($sformatf("rr_d%0d", n), out_data, (n % 4) * 16 + n / 4);
            tick;
        end
        check("rr_end", out_valid, 0);
        out_is_taken = 1'b0;

        // Backpressure holds the output stage
        do_reset;
        in_valid = 4'b1000; set_lane(3, 8'hA5);
        tick;
        in_valid = '0;
        tick;
        check("bp_src0", out_source, 3);
        for (int c = 0; c < 5; c++) begin
            in_valid = 4'b0011; set_lane(0, 8'(8'h60 + c)); set_lane(1, 8'(8'h70 + c));
            tick;
            check($sformatf("bp_v%0d", c), out_valid, 1);
            check($sformatf("bp_d%0d", c), out_data, 8'hA5);
            check($sformatf("bp_s%0d", c), out_source, 3);
        end
        in_valid = '0; out_is_taken = 1'b1;
        tick;
        check("bp_next_src", out_source, 0);
        check("bp_next_d", out_data, 8'h60);
        tick;
        check("bp_next2_src", out_source, 1);
        check("bp_next2_d", out_data, 8'h70);
        out_is_taken = 1'b0;

        // Pop and write in the same cycle on a full lane
        do_reset;
        for (int k = 0; k < 17; k++) begin
            in_valid = 4'b0010; set_lane(1, 8'(8'h80 + k));
            tick;
        end
        check("pw_full", in_is_full[1], 1);
        out_is_taken = 1'b1; set_lane(1, 8'hEE);
        tick;
        check("pw_ovf", overflow[1], 1);
        check("pw_full_drop", in_is_full[1], 0);
        check("pw_stage", out_data, 8'h81);
        out_is_taken = 1'b0; set_lane(1, 8'hEF);
        tick;
        check("pw_accept_full", in_is_full[1], 1);
        check("pw_ovf_sticky", overflow[1], 1);
        in_valid = '0; out_is_taken = 1'b1;
        for (int j = 0; j < 17; j++) begin
            check($sformatf("pw_drain_d%0d", j), out_data, (j < 16) ? 8'(8'h81 + j) : 8'hEF);
            tick;
        end
        check("pw_end", out_valid, 0);
        out_is_taken = 1'b0;

        // Initialize mid-stream with lanes at 5, 0, 9, 16 words
        do_reset;
        for (int c = 0; c < 17; c++) begin
            in_valid = 4'b1000;
            if (c >= 1 && c <= 5) in_valid[0] = 1'b1;
            if (c >= 1 && c <= 9) in_valid[2] = 1'b1;
            set_lane(0, 8'(c)); set_lane(2, 8'(8'h20 + c)); set_lane(3, 8'(8'h30 + c));
            tick;
        end
        check("init_pre_full3", in_is_full[3], 1);
        check("init_pre_src", out_source, 3);
        in_valid = 4'b1111; initialize = 1'b1;
        tick;
        initialize = 1'b0;
        check("init_valid", out_valid, 0);
        check("init_full", in_is_full, 0);
        check("init_afull", in_almost_full, 0);
        check("init_ovf", overflow, 0);
        check("init_data", out_data, 0);
        in_valid = '0;
        tick;
        check("init_flushed", out_valid, 0);
        in_valid = 4'b1111;
        for (int l = 0; l < NUM_IN; l++) set_lane(l, 8'(8'hC0 + l));
        tick;
        in_valid = '0;
        tick;
        check("init_grant_v", out_valid, 1);
        check("init_grant_src", out_source, 0);
        check("init_grant_d", out_data, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
